semafor_multi: RTL and testbench
================================

SEMAFOR_MULTI -- requirements
Module: semafor_multi

Interface
REQ-001 SHALL have parameter N_DIR, default 2, number of vehicle phases (2..4), each served in round-robin order.
REQ-002 SHALL have parameter CNT_W, default 8, timer width; every timing parameter SHALL be >= 1 and <= 2^CNT_W.
REQ-003 SHALL have parameters T_GREEN 20, T_YELLOW 4, T_ALLRED 2, T_PED 10, T_FLASH 8: state durations in clk cycles.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port ped_req, input, 1, synchronous pedestrian button, pulse or level.
REQ-007 SHALL have port night, input, 1, synchronous request for flashing-yellow mode.
REQ-008 SHALL have port red, output, N_DIR, per-phase red lamp.
REQ-009 SHALL have port yellow, output, N_DIR, per-phase yellow lamp.
REQ-010 SHALL have port green, output, N_DIR, per-phase green lamp.
REQ-011 SHALL have port walk, output, 1, pedestrian green.
REQ-012 SHALL have port phase, output, clog2(N_DIR), index of the current or most recent vehicle phase.

Function
REQ-013 SHALL implement the FSM states ALLRED, GREEN, YELLOW, PED and FLASH; outputs SHALL be decoded from registered state only, with no combinational path from input to output.
REQ-014 SHALL load the timer with T_x-1 on entry to state x, decrement it each cycle, and exit when it reaches 0, so each state lasts exactly T_x cycles.
REQ-015 SHALL, in GREEN, drive green[phase]=1 and red=1 on all other phases; in YELLOW, yellow[phase]=1 and other phases red; in ALLRED and PED, red=all ones; any phase SHALL light exactly one lamp outside FLASH.
REQ-016 SHALL transition GREEN -> YELLOW -> ALLRED on timer expiry.
REQ-017 SHALL, on ALLRED expiry, check in priority order: night=1 -> FLASH; else ped_pend=1 -> PED; else GREEN with phase <= (phase+1) mod N_DIR.
REQ-018 SHALL, on PED expiry, go to GREEN with phase <= (phase+1) mod N_DIR; walk=1 only in PED.
REQ-019 SHALL set the ped_pend latch on any cycle with ped_req=1 outside PED, and clear it on PED entry; ped_req during PED SHALL be ignored; further presses while pending SHALL have no effect (no queuing).
REQ-020 SHALL sample night only at ALLRED expiry; night asserted during GREEN/YELLOW SHALL NOT shorten them.
REQ-021 SHALL, in FLASH, drive red=0, green=0, walk=0, and toggle yellow between all ones and all zeros every T_FLASH cycles, starting at all ones.
REQ-022 SHALL, at each FLASH half-period expiry with night=0, go to ALLRED with phase=N_DIR-1; ped_pend SHALL be retained across FLASH.
REQ-023 SHALL wrap phase from N_DIR-1 to 0; it SHALL never exceed N_DIR-1.

Reset
REQ-024 SHALL, on rst=1 and regardless of clk, force state ALLRED, phase=N_DIR-1, timer=T_ALLRED-1, ped_pend=0, red=all ones, yellow=0, green=0, walk=0.
REQ-025 SHALL, after rst deassertion, count cycle 0 as the first rising edge, spend cycles 0..T_ALLRED-1 in ALLRED, then give green to phase 0.

Verification (N_DIR=3, T_GREEN=8, T_YELLOW=3, T_ALLRED=2, T_PED=5, T_FLASH=4)
REQ-026 SHALL verify idle run: release rst, no inputs -> red=111 cycles 0-1; green=001 cycles 2-9; yellow=001 cycles 10-12; red=111 cycles 13-14; green=010 at cycle 15; phase 2 -> 0 wrap at cycle 41.
REQ-027 SHALL verify a pedestrian request: 1-cycle ped_req at cycle 5 -> walk=1, red=111 cycles 15-19; green=010 from cycle 20; walk=0 elsewhere.
REQ-028 SHALL verify presses during PED: ped_req held high for cycles 15-19 -> no second PED, so cycle 20 onward follows the normal rotation without walk; ped_req held high through cycle 20 -> PED after the next ALLRED.
REQ-029 SHALL verify night mode: night=1 from cycle 4 -> phase-0 green/yellow complete; yellow=111 cycles 15-18, yellow=000 cycles 19-22; drop night at cycle 20 -> ALLRED cycles 23-24; green=001 at cycle 25.
REQ-030 SHALL verify reset mid-operation: rst pulsed asynchronously at cycle 11 (in YELLOW) with ped_pend set -> immediately red=111, yellow=000, walk=0; after release, REQ-026 timing repeats with no PED.

Source files
------------

// File: rtl/semafor_multi.sv
// semafor_multi: round-robin traffic light for N_DIR vehicle phases with a
// pedestrian phase and a night flashing-yellow mode.
module semafor_multi #(
  parameter int N_DIR    = 2,
  parameter int CNT_W    = 8,
  parameter int T_GREEN  = 20,
  parameter int T_YELLOW = 4,
  parameter int T_ALLRED = 2,
  parameter int T_PED    = 10,
  parameter int T_FLASH  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ped_req,
  input  logic                       night,
  output logic [N_DIR-1:0]           red,
  output logic [N_DIR-1:0]           yellow,
  output logic [N_DIR-1:0]           green,
  output logic                       walk,
  output logic [$clog2(N_DIR)-1:0]   phase
);
  localparam int PW = $clog2(N_DIR);
  localparam logic [PW-1:0]    LAST = PW'(N_DIR - 1);
  localparam logic [CNT_W-1:0] LD_G = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_Y = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_A = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LD_P = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] LD_F = CNT_W'(T_FLASH - 1);
  typedef enum logic [2:0] {ALLRED, GREEN, YELLOW, PED, FLASH} state_t;
  state_t           state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [PW-1:0]    phase_n, phase_inc;
  logic             ped_pend, ped_pend_n, flash_on, flash_on_n, expired;
  logic [N_DIR-1:0] onehot;
  assign expired   = timer == '0;
  assign phase_inc = phase == LAST ? '0 : phase + PW'(1);
  assign onehot    = N_DIR'(1) << phase;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ALLRED;
      timer    <= LD_A;
      phase    <= LAST;
      ped_pend <= 1'b0;
      flash_on <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      phase    <= phase_n;
      ped_pend <= ped_pend_n;
      flash_on <= flash_on_n;
    end
  end
  always_comb begin
    state_n    = state;
    timer_n    = timer - CNT_W'(1);
    phase_n    = phase;
    flash_on_n = flash_on;
    if (expired) begin
      case (state)
        GREEN: begin
          state_n = YELLOW;
          timer_n = LD_Y;
        end
        YELLOW: begin
          state_n = ALLRED;
          timer_n = LD_A;
        end
        ALLRED: begin
          if (night) begin
            state_n    = FLASH;
            timer_n    = LD_F;
            flash_on_n = 1'b1;
          end else if (ped_pend) begin
            state_n = PED;
            timer_n = LD_P;
          end else begin
            state_n = GREEN;
            timer_n = LD_G;
            phase_n = phase_inc;
          end
        end
        PED: begin
          state_n = GREEN;
          timer_n = LD_G;
          phase_n = phase_inc;
        end
        FLASH: begin
          timer_n = night ? LD_F : LD_A;
          state_n = night ? FLASH : ALLRED;
          phase_n = night ? phase : LAST;
          flash_on_n = night ? ~flash_on : flash_on;
        end
        default: begin
          state_n = ALLRED;
          timer_n = LD_A;
        end
      endcase
    end
    // the press that is served by the PED phase now starting is consumed here
    ped_pend_n = (state_n == PED && state != PED) ? 1'b0 :
                 (ped_req && state != PED)        ? 1'b1 : ped_pend;
  end
  always_comb begin
    red    = (state == GREEN || state == YELLOW) ? ~onehot : state == FLASH ? '0 : '1;
    yellow = state == YELLOW ? onehot : (state == FLASH && flash_on) ? '1 : '0;
    green  = state == GREEN ? onehot : '0;
    walk   = state == PED;
  end
endmodule

// File: tb/tb_semafor_multi.sv
// tb_semafor_multi: scoreboard bench; a cycle model pushes expected lamps per
// cycle, the monitor pops and compares, plus fixed timeline spot checks.
module tb_semafor_multi;
  localparam int N = 3, TG = 8, TY = 3, TA = 2, TP = 5, TF = 4;
  localparam int A = 0, G = 1, Y = 2, P = 3, F = 4;
  logic clk = 0, rst = 0, ped_req = 0, night = 0;
  logic [2:0] red, yellow, green;
  logic walk;
  logic [1:0] phase;
  int checks = 0, failures = 0;
  logic [11:0] exp_q[$];
  int st, left, mph;
  logic pend, fon;

  semafor_multi #(.N_DIR(N), .CNT_W(8), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA),
                  .T_PED(TP), .T_FLASH(TF)) dut (
    .clk(clk), .rst(rst), .ped_req(ped_req), .night(night),
    .red(red), .yellow(yellow), .green(green), .walk(walk), .phase(phase));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs();
    return {red, yellow, green, walk, phase};
  endfunction

  function automatic logic [11:0] exp_out();
    logic [2:0] r, y, g;
    r = '1; y = '0; g = '0;
    for (int i = 0; i < N; i++) begin
      if (st == G && i == mph) begin g[i] = 1'b1; r[i] = 1'b0; end
      if (st == Y && i == mph) begin y[i] = 1'b1; r[i] = 1'b0; end
      if (st == F) begin r[i] = 1'b0; y[i] = fon; end
    end
    return {r, y, g, st == P, 2'(mph)};
  endfunction

  task automatic m_reset();
    st = A; left = TA; mph = N - 1; pend = 1'b0; fon = 1'b0;
  endtask

  task automatic model_edge(input logic p, input logic n);
    logic op;
    int os;
    op = pend;
    os = st;
    if (p && os != P) pend = 1'b1;
    if (left > 1) begin
      left--;
      return;
    end
    case (os)
      G: begin st = Y; left = TY; end
      Y: begin st = A; left = TA; end
      A: if (n) begin st = F; left = TF; fon = 1'b1; end
         else if (op) begin st = P; left = TP; pend = 1'b0; end
         else begin st = G; left = TG; mph = (mph + 1) % N; end
      P: begin st = G; left = TG; mph = (mph + 1) % N; end
      default: if (n) begin fon = !fon; left = TF; end
               else begin st = A; left = TA; mph = N - 1; end
    endcase
  endtask

  function automatic logic stim_ped(input int sc, input int k);
    return ((sc == 1 || sc == 2 || sc == 3 || sc == 5) && k == 5) ||
           (sc == 2 && k >= 15 && k <= 19) || (sc == 3 && k >= 15 && k <= 20);
  endfunction

  function automatic logic stim_night(input int sc, input int k);
    return sc == 4 && k >= 4 && k < 20;
  endfunction

  task automatic spot(input int sc, input int k);
    if (sc == 0 && k == 0)  chk("idle_red_c0", 12'(red), 12'(3'b111));
    if (sc == 0 && k == 2)  chk("idle_green_c2", 12'(green), 12'(3'b001));
    if (sc == 0 && k == 9)  chk("idle_green_c9", 12'(green), 12'(3'b001));
    if (sc == 0 && k == 10) chk("idle_yellow_c10", 12'(yellow), 12'(3'b001));
    if (sc == 0 && k == 14) chk("idle_red_c14", 12'(red), 12'(3'b111));
    if (sc == 0 && k == 15) chk("idle_green_c15", 12'(green), 12'(3'b010));
    if (sc == 0 && k == 40) chk("idle_phase_c40", 12'(phase), 12'd2);
    if (sc == 0 && k == 41) chk("idle_wrap_c41", 12'({phase, green}), 12'({2'd0, 3'b001}));
    if (sc == 1 && k == 14) chk("ped_walk_c14", 12'(walk), 12'd0);
    if (sc == 1 && k == 15) chk("ped_walk_c15", 12'({walk, red}), 12'({1'b1, 3'b111}));
    if (sc == 1 && k == 19) chk("ped_walk_c19", 12'(walk), 12'd1);
    if (sc == 1 && k == 20) chk("ped_green_c20", 12'({walk, green}), 12'({1'b0, 3'b010}));
    if (sc == 2 && k == 20) chk("hold_nowalk_c20", 12'(walk), 12'd0);
    if (sc == 2 && k == 33) chk("hold_green_c33", 12'({walk, green}), 12'({1'b0, 3'b100}));
    if (sc == 3 && k == 33) chk("hold20_walk_c33", 12'(walk), 12'd1);
    if (sc == 3 && k == 38) chk("hold20_green_c38", 12'(green), 12'(3'b100));
    if (sc == 4 && k == 12) chk("night_yellow_c12", 12'(yellow), 12'(3'b001));
    if (sc == 4 && k == 15) chk("night_flash_c15", 12'({red, yellow, green}), 12'({3'b000, 3'b111, 3'b000}));
    if (sc == 4 && k == 19) chk("night_dark_c19", 12'(yellow), 12'(3'b000));
    if (sc == 4 && k == 23) chk("night_allred_c23", 12'({red, phase}), 12'({3'b111, 2'd2}));
    if (sc == 4 && k == 25) chk("night_green_c25", 12'(green), 12'(3'b001));
    if (sc == 6 && k == 15) chk("rst_nowalk_c15", 12'({walk, green}), 12'({1'b0, 3'b010}));
  endtask

  task automatic run_scn(input int sc, input int n);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    exp_q.push_back(exp_out());
    for (int k = 0; k < n; k++) begin
      ped_req = stim_ped(sc, k);
      night   = stim_night(sc, k);
      #1;
      chk($sformatf("sc%0d_c%0d", sc, k), obs(), exp_q.size() != 0 ? exp_q.pop_front() : 12'hxxx);
      spot(sc, k);
      if (sc == 5 && k == 11) begin
        #2 rst = 1'b1;
        #1 chk("async_rst_lamps", 12'({red, yellow, green, walk}),
               12'({3'b111, 3'b000, 3'b000, 1'b0}));
        chk("async_rst_phase", 12'(phase), 12'd2);
        exp_q.delete();
        ped_req = 1'b0;
        return;
      end
      model_edge(ped_req, night);
      exp_q.push_back(exp_out());
      @(negedge clk);
    end
    exp_q.delete();
    ped_req = 1'b0;
    night = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    #1 rst = 1'b1;
    #2 chk("reset_state", obs(), {3'b111, 3'b000, 3'b000, 1'b0, 2'd2});
    run_scn(0, 45);
    run_scn(1, 25);
    run_scn(2, 45);
    run_scn(3, 45);
    run_scn(4, 30);
    run_scn(5, 12);
    @(posedge clk);
    run_scn(6, 45);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
